// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the EX-stage divide issue controller.
// Holds the datapath width, drain length and FSM state encoding.
package div_issue_ctrl_pkg;

    localparam int W       = 24;
    localparam int DRAIN_N = 2;
    localparam int CNT_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE,
        DRAIN
    } state_t;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Pipeline/divider signal bundle for the divide issue controller.
// slave = controller side, master = pipeline plus divider side.
interface div_issue_ctrl_if
    import div_issue_ctrl_pkg::*;
();

    logic         ex_div_i;
    logic         ex_signed_i;
    logic [W-1:0] ex_op1_i;
    logic [W-1:0] ex_op2_i;
    logic         ex_mthi_i;
    logic         ex_mtlo_i;
    logic [W-1:0] ex_wdata_i;
    logic         flush_i;
    logic         stall_o;
    logic         div_start_o;
    logic         div_annul_o;
    logic         div_signed_o;
    logic [W-1:0] div_op1_o;
    logic [W-1:0] div_op2_o;
    logic [W-1:0] div_quot_i;
    logic [W-1:0] div_rem_i;
    logic         div_ready_i;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;
    logic         dz_o;

    modport slave (
        input  ex_div_i, ex_signed_i, ex_op1_i, ex_op2_i,
        input  ex_mthi_i, ex_mtlo_i, ex_wdata_i, flush_i,
        input  div_quot_i, div_rem_i, div_ready_i,
        output stall_o, div_start_o, div_annul_o, div_signed_o,
        output div_op1_o, div_op2_o, hi_o, lo_o, dz_o
    );

    modport master (
        output ex_div_i, ex_signed_i, ex_op1_i, ex_op2_i,
        output ex_mthi_i, ex_mtlo_i, ex_wdata_i, flush_i,
        output div_quot_i, div_rem_i, div_ready_i,
        input  stall_o, div_start_o, div_annul_o, div_signed_o,
        input  div_op1_o, div_op2_o, hi_o, lo_o, dz_o
    );

endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage controller for the iterative divider; owns HI/LO.
// Stalls the pipeline while a DIV/DIVU is in flight, then commits.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    div_issue_ctrl_if.slave       bus
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [W-1:0]     r_op1;
    logic [W-1:0]     r_op2;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;
    logic             r_signed;
    logic             r_dz_pend;
    logic             r_dz;
    logic             w_issue;
    logic             w_stall;
    logic             w_start;
    logic             w_annul;

    assign w_issue = bus.ex_div_i & ~bus.flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_signed  <= 1'b0;
            r_dz_pend <= 1'b0;
            r_dz      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_dz    <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_op1     <= bus.ex_op1_i;
                        r_op2     <= bus.ex_op2_i;
                        r_signed  <= bus.ex_signed_i;
                        r_dz_pend <= (bus.ex_op2_i == '0);
                    end else if (!bus.flush_i) begin
                        if (bus.ex_mthi_i) r_hi <= bus.ex_wdata_i;
                        if (bus.ex_mtlo_i) r_lo <= bus.ex_wdata_i;
                    end
                end
                WAIT: begin
                    // flush wins over a same-cycle ready: result is discarded
                    if (bus.flush_i) begin
                        r_cnt <= CNT_W'(DRAIN_N);
                    end else if (bus.div_ready_i) begin
                        r_hi <= bus.div_rem_i;
                        r_lo <= bus.div_quot_i;
                        r_dz <= r_dz_pend;
                    end
                end
                DRAIN: r_cnt <= r_cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:  if (w_issue) w_next = WAIT;
            WAIT: begin
                if (bus.flush_i)          w_next = DRAIN;
                else if (bus.div_ready_i) w_next = DONE;
            end
            DONE:  w_next = IDLE;
            DRAIN: if (r_cnt <= CNT_W'(1)) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_stall = 1'b0;
        w_start = 1'b0;
        w_annul = 1'b0;
        unique case (r_state)
            IDLE:  w_stall = w_issue;
            WAIT: begin
                w_stall = 1'b1;
                w_start = ~bus.flush_i;
                w_annul = bus.flush_i;
            end
            DRAIN: w_stall = bus.ex_div_i;
            default: ;
        endcase
    end

    assign bus.stall_o      = w_stall;
    assign bus.div_start_o  = w_start;
    assign bus.div_annul_o  = w_annul;
    assign bus.div_signed_o = r_signed;
    assign bus.div_op1_o    = r_op1;
    assign bus.div_op2_o    = r_op2;
    assign bus.hi_o         = r_hi;
    assign bus.lo_o         = r_lo;
    assign bus.dz_o         = r_dz;

endmodule
